// File: rtl/butterfly_pipe.sv
// Pipelined Kyber/Dilithium NTT butterfly (CT, GS or bypass per beat) with valid/ready handshake.
// Global-stall pipeline: every stage holds while the output beat is refused.
module butterfly_pipe #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] twiddle_i,
  input  logic              sel_red_i,
  input  logic [1:0]        mode_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

  localparam int unsigned PROD_W  = 2 * DATA_W;
  // Reduction sits right after the product register, or in the last stage when STAGES is 2.
  localparam int unsigned RED_STG = (STAGES > 2) ? 1 : STAGES - 1;
  localparam logic [DATA_W:0] Q_KYB = (DATA_W+1)'(3329);
  localparam logic [DATA_W:0] Q_DIL = (DATA_W+1)'(8380417);
  localparam logic [1:0] MODE_CT = 2'b00;
  localparam logic [1:0] MODE_GS = 2'b01;

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic              sel);
    logic [DATA_W:0] q;
    logic [DATA_W:0] s;
    q = sel ? Q_KYB : Q_DIL;
    s = {1'b0, x} + {1'b0, y};
    if (s >= q) s = s - q;
    return DATA_W'(s);
  endfunction

  // Wrapped difference plus q lands back in [0,q) when x < y.
  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic              sel);
    logic [DATA_W:0] q;
    logic [DATA_W:0] d;
    q = sel ? Q_KYB : Q_DIL;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + q;
    return DATA_W'(d);
  endfunction

  function automatic logic [DATA_W-1:0] red_mod(input logic [PROD_W-1:0] p,
                                                input logic              sel);
    logic [PROD_W-1:0] r;
    r = sel ? (p % PROD_W'(3329)) : (p % PROD_W'(8380417));
    return DATA_W'(r);
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [1:0]        mode_q [STAGES];
  logic [1:0]        mode_d [STAGES];
  logic              sel_q  [STAGES];
  logic              sel_d  [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [DATA_W-1:0] x_q    [STAGES];
  logic [DATA_W-1:0] x_d    [STAGES];
  logic [PROD_W-1:0] y_q    [STAGES];
  logic [PROD_W-1:0] y_d    [STAGES];
  logic [DATA_W-1:0] t_c;
  logic              stall;

  assign stall       = vld_q[STAGES-1] & ~out_ready_i;
  assign in_ready_o  = ~stall;
  assign out_valid_o = vld_q[STAGES-1];
  assign a_o         = x_q[STAGES-1];
  assign b_o         = DATA_W'(y_q[STAGES-1]);
  assign tag_o       = tag_q[STAGES-1];
  assign busy_o      = |vld_q;

  // Stage advance: x carries the a-side operand/result, y the product or b-side result.
  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    sel_d  = sel_q;
    tag_d  = tag_q;
    x_d    = x_q;
    y_d    = y_q;
    t_c    = '0;
    if (!stall) begin
      vld_d[0]  = in_valid_i;
      mode_d[0] = mode_i;
      sel_d[0]  = sel_red_i;
      tag_d[0]  = tag_i;
      case (mode_i)
        MODE_CT: begin
          x_d[0] = a_i;
          y_d[0] = PROD_W'(twiddle_i) * PROD_W'(b_i);
        end
        MODE_GS: begin
          x_d[0] = add_mod(a_i, b_i, sel_red_i);
          y_d[0] = PROD_W'(twiddle_i) * PROD_W'(sub_mod(a_i, b_i, sel_red_i));
        end
        default: begin
          x_d[0] = a_i;
          y_d[0] = PROD_W'(b_i);
        end
      endcase
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        mode_d[k] = mode_q[k-1];
        sel_d[k]  = sel_q[k-1];
        tag_d[k]  = tag_q[k-1];
        x_d[k]    = x_q[k-1];
        y_d[k]    = y_q[k-1];
        if (k == RED_STG && !mode_q[k-1][1]) begin
          y_d[k] = PROD_W'(red_mod(y_q[k-1], sel_q[k-1]));
        end
        if (k == STAGES - 1 && mode_q[k-1] == MODE_CT) begin
          t_c    = DATA_W'(y_d[k]);
          x_d[k] = add_mod(x_q[k-1], t_c, sel_q[k-1]);
          y_d[k] = PROD_W'(sub_mod(x_q[k-1], t_c, sel_q[k-1]));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        mode_q[k] <= '0;
        sel_q[k]  <= 1'b0;
        tag_q[k]  <= '0;
        x_q[k]    <= '0;
        y_q[k]    <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      sel_q  <= sel_d;
      tag_q  <= tag_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed + randomized bench for butterfly_pipe, checked against an arithmetic reference model.
module tb_butterfly_pipe;

  localparam int unsigned DATA_W = 23;
  localparam int unsigned STAGES = 3;
  localparam int unsigned TAG_W  = 8;
  localparam longint QK = 3329;
  localparam longint QD = 8380417;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] a_i, b_i, twiddle_i;
  logic              sel_red_i;
  logic [1:0]        mode_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] a_o, b_o;
  logic [TAG_W-1:0]  tag_o;
  logic              busy_o;

  butterfly_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .twiddle_i(twiddle_i), .sel_red_i(sel_red_i), .mode_i(mode_i),
    .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .a_o(a_o),
    .b_o(b_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint a;
    longint b;
    int     tag;
    int     cyc;
    bit     lat;
  } exp_t;

  exp_t              exp_q[$];
  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  bit                chk_lat = 1'b0;
  bit                bp_armed = 1'b0;
  bit                bp_started = 1'b0;
  int                bp_left = 0;
  bit                rnd_rdy = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] pa, pb;
  logic [TAG_W-1:0]  pt;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  // Butterfly equations computed directly with integer modular arithmetic.
  function automatic void ref_bfly(input longint a, input longint b, input longint w,
                                   input bit sel, input int mode,
                                   output longint ra, output longint rb);
    longint q, t;
    q = sel ? QK : QD;
    case (mode)
      0: begin
        t  = (w * b) % q;
        ra = (a + t) % q;
        rb = (a - t + q) % q;
      end
      1: begin
        ra = (a + b) % q;
        rb = (w * ((a - b + q) % q)) % q;
      end
      default: begin
        ra = a;
        rb = b;
      end
    endcase
  endfunction

  task automatic mon_check();
    exp_t e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid_o), 64'd1);
      chk("hold_a", 64'(a_o), 64'(pa));
      chk("hold_b", 64'(b_o), 64'(pb));
      chk("hold_tag", 64'(tag_o), 64'(pt));
    end
    if (out_valid_o && !out_ready_i) chk("stall_in_ready", 64'(in_ready_o), 64'd0);
    if (out_valid_o && out_ready_i) begin
      chk("unexpected_output", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("a_o", 64'(a_o), 64'(e.a));
        chk("b_o", 64'(b_o), 64'(e.b));
        chk("tag_o", 64'(tag_o), 64'(e.tag));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
      end
    end
    prev_stall = out_valid_o && !out_ready_i;
    pa = a_o;
    pb = b_o;
    pt = tag_o;
  endtask

  // One clock: sample outputs on the falling edge, drive after the rising edge.
  task automatic step();
    @(negedge clk_i);
    mon_check();
    @(posedge clk_i);
    cyc++;
    #1;
    if (bp_armed && !bp_started && out_valid_o) begin
      bp_started  = 1'b1;
      bp_left     = 5;
      out_ready_i = 1'b0;
    end else if (bp_left > 0) begin
      bp_left--;
      if (bp_left == 0) out_ready_i = 1'b1;
    end
    if (rnd_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input longint a, input longint b, input longint w, input bit sel,
                      input int mode, input int tag, input longint ea, input longint eb);
    exp_t e;
    int   guard;
    in_valid_i = 1'b1;
    a_i        = DATA_W'(a);
    b_i        = DATA_W'(b);
    twiddle_i  = DATA_W'(w);
    sel_red_i  = sel;
    mode_i     = 2'(mode);
    tag_i      = TAG_W'(tag);
    #1;
    guard = 0;
    while (!in_ready_o && guard < 100) begin
      step();
      #1;
      guard++;
    end
    chk("accept", 64'(in_ready_o), 64'd1);
    if (in_ready_o) begin
      e.a = ea;
      e.b = eb;
      e.tag = tag;
      e.cyc = cyc;
      e.lat = chk_lat;
      exp_q.push_back(e);
    end
    step();
  endtask

  task automatic send_rand(input int mode, input bit sel, input int tag);
    longint q, a, b, w, ra, rb;
    q = sel ? QK : QD;
    a = longint'($urandom_range(0, 32'(q - 1)));
    b = longint'($urandom_range(0, 32'(q - 1)));
    w = longint'($urandom_range(0, 32'(q - 1)));
    ref_bfly(a, b, w, sel, mode, ra, rb);
    send(a, b, w, sel, mode, tag, ra, rb);
  endtask

  task automatic drain();
    int g;
    in_valid_i = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      step();
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    a_i         = '0;
    b_i         = '0;
    twiddle_i   = '0;
    sel_red_i   = 1'b0;
    mode_i      = 2'b00;
    tag_i       = '0;
    out_ready_i = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_a_o", 64'(a_o), 64'd0);
    chk("rst_b_o", 64'(b_o), 64'd0);
    chk("rst_tag_o", 64'(tag_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Known-answer beats with exact latency.
    chk_lat = 1'b1;
    send(100, 200, 17, 1'b1, 0, 8'h11, 171, 29);
    drain();
    send(5, 10, 2, 1'b1, 1, 8'h22, 15, 3319);
    send(0, 8380416, 8380416, 1'b0, 0, 8'h33, 1, 8380416);
    drain();
    send(1234, 4321, 999, 1'b1, 2, 8'h44, 1234, 4321);
    send(1234, 4321, 999, 1'b1, 3, 8'h55, 1234, 4321);
    send(7654321, 1234567, 42, 1'b0, 3, 8'h66, 7654321, 1234567);
    drain();

    // Back-to-back stream alternating mode and modulus.
    for (int i = 0; i < 16; i++) begin
      send_rand(i % 2, 1'(i % 2) ^ 1'((i / 8) % 2), int'($urandom_range(0, 255)));
    end
    drain();

    // Back-pressure: five refused cycles once the first output appears.
    chk_lat    = 1'b0;
    bp_armed   = 1'b1;
    bp_started = 1'b0;
    for (int i = 0; i < 8; i++) send_rand(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 100 + i);
    drain();
    chk("bp_stalled", 64'(bp_started), 64'd1);
    bp_armed = 1'b0;

    // Random modes, moduli, input gaps and consumer readiness.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_rand(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        step();
      end
    end
    rnd_rdy     = 1'b0;
    out_ready_i = 1'b1;
    drain();

    // Reset with three beats in flight.
    chk_lat = 1'b1;
    send_rand(0, 1'b1, 8'hA1);
    send_rand(1, 1'b0, 8'hA2);
    send_rand(0, 1'b0, 8'hA3);
    in_valid_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
    step();
    step();
    rst_ni = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
    repeat (8) step();
    chk("midrst_no_stale", 64'(busy_o), 64'd0);
    send(100, 200, 17, 1'b1, 0, 8'h5A, 171, 29);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
